// File: rtl/demux4_buf_if.sv
// rtl/demux4_buf_if.sv - handshake bundle for the 4-way buffered demux
// slave modport faces the demux, master modport faces upstream and the four consumers.
interface demux4_buf_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] d;
    logic [1:0]       s;
    logic [WIDTH-1:0] y0;
    logic [WIDTH-1:0] y1;
    logic [WIDTH-1:0] y2;
    logic [WIDTH-1:0] y3;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;

    modport master (
        output in_valid, d, s, out_ready,
        input  in_ready, y0, y1, y2, y3, out_valid
    );

    modport slave (
        input  in_valid, d, s, out_ready,
        output in_ready, y0, y1, y2, y3, out_valid
    );
endinterface

// File: rtl/demux4_buf.sv
// rtl/demux4_buf.sv - 1-to-4 demux with a one-entry skid-free buffer per channel
// Define DEMUX4_BCAST_EN to add the bcast input that loads all four channels at once.
module demux4_buf #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          reset,
`ifdef DEMUX4_BCAST_EN
    input  logic          bcast,
`endif
    demux4_buf_if.slave   bus
);
    logic [WIDTH-1:0] y_q [4];
    logic [3:0]       vld_q;
    logic [3:0]       space;
    logic [3:0]       load;
    logic             ready_c;

    // A channel can take a word if empty or if its consumer drains it on this edge.
    always_comb begin
        space   = ~vld_q | bus.out_ready;
        load    = 4'b0000;
        ready_c = space[bus.s];
`ifdef DEMUX4_BCAST_EN
        if (bcast) begin
            ready_c = &space;
        end
`endif
        ready_c = ready_c & reset;
        if (bus.in_valid && ready_c) begin
            load[bus.s] = 1'b1;
`ifdef DEMUX4_BCAST_EN
            if (bcast) begin
                load = 4'b1111;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                y_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (load[i]) begin
                    y_q[i]   <= bus.d;
                    vld_q[i] <= 1'b1;
                end else if (vld_q[i] && bus.out_ready[i]) begin
                    vld_q[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready  = ready_c;
    assign bus.out_valid = vld_q;
    assign bus.y0        = y_q[0];
    assign bus.y1        = y_q[1];
    assign bus.y2        = y_q[2];
    assign bus.y3        = y_q[3];
endmodule

// File: tb/tb_demux4_buf.sv
// tb/tb_demux4_buf.sv - directed self-checking bench for demux4_buf
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_demux4_buf;
    logic clk;
    logic reset;
`ifdef DEMUX4_BCAST_EN
    logic bcast;
`endif
    int   vectors;
    int   miscompares;

    demux4_buf_if #(.WIDTH(8)) bus ();

    demux4_buf #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
`ifdef DEMUX4_BCAST_EN
        .bcast (bcast),
`endif
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        reset         = 1'b0;
`ifdef DEMUX4_BCAST_EN
        bcast         = 1'b0;
`endif
        bus.in_valid  = 1'b1;
        bus.d         = 8'h00;
        bus.s         = 2'd0;
        bus.out_ready = 4'b0000;
        #3;
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_y0", 32'(bus.y0), 32'h0);
        chk("rst_y1", 32'(bus.y1), 32'h0);
        chk("rst_y2", 32'(bus.y2), 32'h0);
        chk("rst_y3", 32'(bus.y3), 32'h0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'h0);

        step();
        reset    = 1'b1;
        bus.s    = 2'd2;
        bus.d    = 8'hA5;
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'h1);
        step();
        bus.in_valid = 1'b0;
        chk("route_out_valid", 32'(bus.out_valid), 32'h4);
        chk("route_y2", 32'(bus.y2), 32'hA5);
        step();
        step();
        chk("hold_out_valid", 32'(bus.out_valid), 32'h4);
        chk("hold_y2", 32'(bus.y2), 32'hA5);

        bus.in_valid = 1'b1;
        bus.s        = 2'd1;
        bus.d        = 8'h11;
        step();
        chk("fill1_out_valid", 32'(bus.out_valid), 32'h6);
        bus.d = 8'h3C;
        #1;
        chk("stall1_in_ready", 32'(bus.in_ready), 32'h0);
        step();
        chk("stall1_out_valid", 32'(bus.out_valid), 32'h6);
        chk("stall1_y1", 32'(bus.y1), 32'h11);
        bus.s = 2'd3;
        #1;
        chk("iso3_in_ready", 32'(bus.in_ready), 32'h1);
        step();
        bus.in_valid = 1'b0;
        chk("iso3_out_valid", 32'(bus.out_valid), 32'hE);
        chk("iso3_y3", 32'(bus.y3), 32'h3C);

        bus.out_ready = 4'b0100;
        step();
        bus.out_ready = 4'b0000;
        chk("drain2_out_valid", 32'(bus.out_valid), 32'hA);
        chk("drain2_y2", 32'(bus.y2), 32'hA5);

        bus.out_ready = 4'b0001;
        bus.in_valid  = 1'b1;
        bus.s         = 2'd0;
        bus.d         = 8'h01;
        #1;
        chk("b2b_ready_a", 32'(bus.in_ready), 32'h1);
        step();
        chk("b2b_y0_a", 32'(bus.y0), 32'h01);
        chk("b2b_ov_a", 32'(bus.out_valid), 32'hB);
        bus.d = 8'h02;
        #1;
        chk("b2b_ready_b", 32'(bus.in_ready), 32'h1);
        step();
        chk("b2b_y0_b", 32'(bus.y0), 32'h02);
        bus.d = 8'h03;
        #1;
        chk("b2b_ready_c", 32'(bus.in_ready), 32'h1);
        step();
        chk("b2b_y0_c", 32'(bus.y0), 32'h03);
        chk("b2b_ov_c", 32'(bus.out_valid), 32'hB);
        bus.in_valid = 1'b0;
        step();
        chk("b2b_drained_ov", 32'(bus.out_valid), 32'hA);
        chk("b2b_drained_y0", 32'(bus.y0), 32'h03);
        bus.out_ready = 4'b0000;

        bus.in_valid = 1'b1;
        bus.d        = 8'h77;
        step();
        bus.in_valid = 1'b0;
        chk("pre_rst_ov", 32'(bus.out_valid), 32'hB);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_ov", 32'(bus.out_valid), 32'h0);
        chk("async_rst_y0", 32'(bus.y0), 32'h0);
        chk("async_rst_y3", 32'(bus.y3), 32'h0);
        chk("async_rst_ready", 32'(bus.in_ready), 32'h0);
        #1;
        reset = 1'b1;
        step();
        chk("after_rst_ov", 32'(bus.out_valid), 32'h0);
        chk("after_rst_y3", 32'(bus.y3), 32'h0);

`ifdef DEMUX4_BCAST_EN
        bcast        = 1'b1;
        bus.in_valid = 1'b1;
        bus.s        = 2'd1;
        bus.d        = 8'h5A;
        #1;
        chk("bc_ready_empty", 32'(bus.in_ready), 32'h1);
        step();
        chk("bc_out_valid", 32'(bus.out_valid), 32'hF);
        chk("bc_y0", 32'(bus.y0), 32'h5A);
        chk("bc_y1", 32'(bus.y1), 32'h5A);
        chk("bc_y2", 32'(bus.y2), 32'h5A);
        chk("bc_y3", 32'(bus.y3), 32'h5A);
        bus.out_ready = 4'b1110;
        #1;
        chk("bc_ready_full", 32'(bus.in_ready), 32'h0);
        bus.out_ready = 4'b1111;
        #1;
        chk("bc_ready_draining", 32'(bus.in_ready), 32'h1);
        bus.in_valid  = 1'b0;
        bcast         = 1'b0;
        bus.out_ready = 4'b0000;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/demux4_buf.md
DEMUX4_BUF -- requirements
Module: demux4_buf

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the data width of the input and of each output channel.
REQ-002 The module SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port in_valid, input, 1 bit: the upstream word on d is valid.
REQ-005 The module SHALL have port in_ready, output, 1 bit: the block accepts d this cycle.
REQ-006 The module SHALL have port d, input, WIDTH bits: the upstream data word.
REQ-007 The module SHALL have port s, input, 2 bits: the destination channel index (0..3).
REQ-008 The module SHALL have ports y0, y1, y2, y3, output, WIDTH bits each: the channel data.
REQ-009 The module SHALL have port out_valid, output, 4 bits: bit i is set when yi holds a word.
REQ-010 The module SHALL have port out_ready, input, 4 bits: bit i is set when channel i's consumer takes yi.

Function
REQ-011 Each channel i SHALL hold a one-entry buffer: data register yi plus flag out_valid[i].
REQ-012 Without broadcast, in_ready SHALL be combinational: in_ready = !out_valid[s] || out_ready[s].
REQ-013 An accept SHALL occur when in_valid && in_ready; at that edge, y[s] <= d and out_valid[s] <= 1.
REQ-014 s and d SHALL be sampled only at accept; a change to s while in_valid is high and not accepted is legal.
REQ-015 Latency SHALL be exactly one cycle, from the accept edge to out_valid[s] high.
REQ-016 A drain SHALL occur on channel i when out_valid[i] && out_ready[i]; out_valid[i] clears at that edge unless the same edge reloads channel i.
REQ-017 A simultaneous drain and reload of the same channel SHALL give a new word every cycle, with no bubble.
REQ-018 While out_valid[i] is high and out_ready[i] is low, yi SHALL stay stable.
REQ-019 Channels SHALL be independent; a stalled channel SHALL NOT block accepts to other channels.
REQ-020 yi SHALL change only on a load; a drain clears out_valid[i] but leaves yi unchanged.
REQ-021 out_ready[i] while out_valid[i] is low SHALL have no effect.
REQ-022 No word SHALL be dropped or duplicated; each accept SHALL produce exactly one drain (or one drain per channel when broadcast).

Reset
REQ-023 While reset is low, out_valid SHALL be 4'b0000, y0..y3 SHALL be 0, and in_ready SHALL be 0.
REQ-024 Assertion of reset mid-operation SHALL discard all buffered words immediately, without waiting for a clock edge.
REQ-025 After reset deasserts, the first accept SHALL be possible at the first rising edge.

Configuration
REQ-026 With macro DEMUX4_BCAST_EN defined, the module SHALL add input port bcast, 1 bit.
REQ-027 When bcast is high, in_ready SHALL be the AND over all i of (!out_valid[i] || out_ready[i]), and an accept SHALL load d into all four channels and set out_valid to 4'b1111.
REQ-028 When bcast is low, or when the macro is undefined, behaviour SHALL be exactly REQ-012..REQ-022 and s SHALL be ignored only during broadcast.
REQ-029 Without DEMUX4_BCAST_EN, the bcast port and its logic SHALL be absent.

Verification
REQ-030 Post-reset: hold reset low, then release -> out_valid=0000, y0..y3=0; in_ready=1 on the first cycle with in_valid=1.
REQ-031 Single route: d=8'hA5, s=2, in_valid=1 for one cycle, out_ready=0000 -> next cycle out_valid=0100, y2=A5, and y2 holds until out_ready[2]=1.
REQ-032 Stall isolation: channel 1 full with out_ready[1]=0; present s=1 then s=3 with d=8'h3C -> s=1 gives in_ready=0; s=3 is accepted and y3=3C.
REQ-033 Back-to-back: s=0, d=01,02,03 on consecutive cycles, out_ready[0]=1 -> y0 equals 01,02,03 on consecutive cycles, in_ready stays 1, no bubbles.
REQ-034 Reset mid-operation: channels 0 and 3 full, reset low asynchronously between edges -> out_valid=0000 immediately; the old words never appear.
REQ-035 Broadcast (DEMUX4_BCAST_EN): bcast=1, d=8'h5A, all channels empty -> next cycle out_valid=1111 and y0..y3=5A; with any channel full and not ready, in_ready=0.
